// File: rtl/d_axi_bridge_if.sv
// AXI4 single-beat channel bundle between the data-cache bridge (master)
// and the SoC interconnect (slave).
interface d_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/d_axi_bridge.sv
// Single-outstanding bridge: turns each strobed data-cache word request into
// one single-beat AXI4 read or write and pulses c_ready on completion.
module d_axi_bridge #(
  parameter int          A_WIDTH = 32,
  parameter logic [3:0]  AXI_ID  = 4'd1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] c_a,
  input  logic [31:0]        c_wdata,
  output logic [31:0]        c_rdata,
  input  logic               c_strobe,
  input  logic               c_rw,
  output logic               c_ready,
  output logic               bus_err,
  d_axi_bridge_if.master     axi
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WREQ, WRESP, DONE
  } state_t;

  state_t             state;
  logic [A_WIDTH-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               aw_done;
  logic               w_done;
  logic               aw_hs;
  logic               w_hs;
  logic               unused_inputs;

  assign aw_hs = axi.awvalid & axi.awready;
  assign w_hs  = axi.wvalid & axi.wready;

  // Single-beat, full-word, incrementing transfers only.
  assign axi.arid    = AXI_ID;
  assign axi.araddr  = 32'(addr_q);
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = 32'(addr_q);
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = 4'hF;
  assign axi.wlast   = 1'b1;

  // Only one beat is ever outstanding, so IDs and rlast carry no information.
  assign unused_inputs = ^{axi.rid, axi.rlast, axi.bid};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      c_rdata     <= '0;
      c_ready     <= 1'b0;
      bus_err     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c_strobe) begin
            addr_q  <= c_a;
            wdata_q <= c_wdata;
            if (c_rw) begin
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WREQ;
            end else begin
              axi.arvalid <= 1'b1;
              state       <= RADDR;
            end
          end
        end
        RADDR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RDATA;
          end
        end
        RDATA: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            c_rdata    <= axi.rdata;
            if (axi.rresp != 2'b00) bus_err <= 1'b1;
            c_ready    <= 1'b1;
            state      <= DONE;
          end
        end
        WREQ: begin
          // AW and W complete independently; the flags remember which is done.
          if (aw_hs) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            axi.bready <= 1'b1;
            state      <= WRESP;
          end
        end
        WRESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            if (axi.bresp != 2'b00) bus_err <= 1'b1;
            c_ready    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          c_ready <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_axi_bridge.sv
// Directed bench for d_axi_bridge: the bench plays the AXI slave and the cache.
module tb_d_axi_bridge;

  logic        clk;
  logic        clrn;
  logic [31:0] c_a;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_strobe;
  logic        c_rw;
  logic        c_ready;
  logic        bus_err;

  int n_chk;
  int n_fail;
  int ar_cnt, aw_cnt, w_cnt, b_cnt, cr_cnt;
  int ar0, aw0, w0, b0, cr0;

  d_axi_bridge_if axi ();

  d_axi_bridge #(.A_WIDTH(32), .AXI_ID(4'd1)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .c_a      (c_a),
    .c_wdata  (c_wdata),
    .c_rdata  (c_rdata),
    .c_strobe (c_strobe),
    .c_rw     (c_rw),
    .c_ready  (c_ready),
    .bus_err  (bus_err),
    .axi      (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor for duplicate-transaction and pulse counting.
  initial begin
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; cr_cnt = 0;
  end
  always @(posedge clk) begin
    if (clrn) begin
      if (axi.arvalid && axi.arready) ar_cnt++;
      if (axi.awvalid && axi.awready) aw_cnt++;
      if (axi.wvalid && axi.wready)   w_cnt++;
      if (axi.bvalid && axi.bready)   b_cnt++;
      if (c_ready)                    cr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; cr0 = cr_cnt;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    clrn = 1'b0; c_a = '0; c_wdata = '0; c_strobe = 1'b0; c_rw = 1'b0;
    axi.arready = 1'b0; axi.rid = 4'd1; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b1; axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = 4'd1; axi.bresp = 2'b00; axi.bvalid = 1'b0;

    // Reset state
    #3;
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid",  axi.wvalid,  1'b0);
    chk("rst_rready",  axi.rready,  1'b0);
    chk("rst_bready",  axi.bready,  1'b0);
    chk("rst_c_ready", c_ready,     1'b0);
    chk("rst_c_rdata", c_rdata,     32'h0);
    chk("rst_bus_err", bus_err,     1'b0);
    chk("const_arlen", axi.arlen,   8'h0);
    chk("const_arsize", axi.arsize, 3'b010);
    chk("const_arburst", axi.arburst, 2'b01);
    step(); clrn = 1'b1; step();

    // Read, zero-wait slave
    c_strobe = 1'b1; c_rw = 1'b0; c_a = 32'h1FC0_0010;
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b00;
    step();
    chk("rd_arvalid_c1", axi.arvalid, 1'b1);
    chk("rd_araddr", axi.araddr, 32'h1FC0_0010);
    chk("rd_arid", axi.arid, 4'd1);
    c_strobe = 1'b0; c_a = 32'h0;
    step();
    chk("rd_rready_c2", axi.rready, 1'b1);
    chk("rd_arvalid_c2", axi.arvalid, 1'b0);
    chk("rd_c_ready_c2", c_ready, 1'b0);
    step();
    chk("rd_c_ready_c3", c_ready, 1'b1);
    chk("rd_c_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("rd_rready_c3", axi.rready, 1'b0);
    axi.arready = 1'b0; axi.rvalid = 1'b0;
    step();
    chk("rd_c_ready_c4", c_ready, 1'b0);

    // Write, wready two cycles after awready
    c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h0000_0100; c_wdata = 32'h1234_5678;
    axi.awready = 1'b1; axi.wready = 1'b0;
    step();
    chk("wr_awvalid_c1", axi.awvalid, 1'b1);
    chk("wr_wvalid_c1", axi.wvalid, 1'b1);
    chk("wr_awaddr", axi.awaddr, 32'h0000_0100);
    chk("wr_wdata", axi.wdata, 32'h1234_5678);
    chk("wr_wstrb", axi.wstrb, 4'hF);
    chk("wr_wlast", axi.wlast, 1'b1);
    chk("wr_awid", axi.awid, 4'd1);
    c_strobe = 1'b0; c_wdata = 32'hFFFF_FFFF;
    step();
    chk("wr_awvalid_c2", axi.awvalid, 1'b0);
    chk("wr_wvalid_c2", axi.wvalid, 1'b1);
    chk("wr_bready_c2", axi.bready, 1'b0);
    axi.awready = 1'b0;
    step();
    chk("wr_wvalid_c3", axi.wvalid, 1'b1);
    chk("wr_wdata_c3", axi.wdata, 32'h1234_5678);
    chk("wr_bready_c3", axi.bready, 1'b0);
    axi.wready = 1'b1;
    step();
    chk("wr_wvalid_c4", axi.wvalid, 1'b0);
    chk("wr_bready_c4", axi.bready, 1'b1);
    axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    step();
    chk("wr_c_ready_c5", c_ready, 1'b1);
    chk("wr_bready_c5", axi.bready, 1'b0);
    chk("wr_c_rdata_kept", c_rdata, 32'hDEAD_BEEF);
    chk("wr_bus_err_ok", bus_err, 1'b0);
    axi.bvalid = 1'b0;
    step();
    chk("wr_c_ready_c6", c_ready, 1'b0);

    // Simultaneous AW/W acceptance, SLVERR response
    c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h0000_0200; c_wdata = 32'hA5A5_0001;
    axi.awready = 1'b1; axi.wready = 1'b1;
    step();
    chk("sim_awvalid_c1", axi.awvalid, 1'b1);
    chk("sim_wvalid_c1", axi.wvalid, 1'b1);
    c_strobe = 1'b0;
    step();
    chk("sim_bready_c2", axi.bready, 1'b1);
    chk("sim_awvalid_c2", axi.awvalid, 1'b0);
    chk("sim_wvalid_c2", axi.wvalid, 1'b0);
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10;
    step();
    chk("sim_c_ready_c3", c_ready, 1'b1);
    chk("sim_bus_err", bus_err, 1'b1);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    step();

    // Back-to-back read then write with c_strobe held high
    snap();
    c_strobe = 1'b1; c_rw = 1'b0; c_a = 32'h0000_0400;
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'h5555_AAAA; axi.rresp = 2'b00;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    step();
    chk("b2b_araddr", axi.araddr, 32'h0000_0400);
    c_rw = 1'b1; c_a = 32'h0000_0800; c_wdata = 32'h0BAD_F00D;
    step();
    chk("b2b_awvalid_rd", axi.awvalid, 1'b0);
    step();
    chk("b2b_c_ready_rd", c_ready, 1'b1);
    chk("b2b_c_rdata", c_rdata, 32'h5555_AAAA);
    chk("b2b_bus_err_sticky", bus_err, 1'b1);
    step();
    chk("b2b_idle_c_ready", c_ready, 1'b0);
    chk("b2b_idle_awvalid", axi.awvalid, 1'b0);
    chk("b2b_idle_arvalid", axi.arvalid, 1'b0);
    step();
    chk("b2b_awvalid", axi.awvalid, 1'b1);
    chk("b2b_awaddr", axi.awaddr, 32'h0000_0800);
    chk("b2b_wdata", axi.wdata, 32'h0BAD_F00D);
    chk("b2b_arvalid_wr", axi.arvalid, 1'b0);
    step();
    chk("b2b_bready", axi.bready, 1'b1);
    step();
    chk("b2b_c_ready_wr", c_ready, 1'b1);
    c_strobe = 1'b0;
    step();
    chk("b2b_end_c_ready", c_ready, 1'b0);
    chk("b2b_ar_count", ar_cnt - ar0, 1);
    chk("b2b_aw_count", aw_cnt - aw0, 1);
    chk("b2b_w_count", w_cnt - w0, 1);
    chk("b2b_b_count", b_cnt - b0, 1);
    chk("b2b_ready_count", cr_cnt - cr0, 2);
    chk("b2b_bus_err_end", bus_err, 1'b1);
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.awready = 1'b0;
    axi.wready = 1'b0; axi.bvalid = 1'b0;
    step();

    // Reset asserted in RDATA with rvalid low
    c_strobe = 1'b1; c_rw = 1'b0; c_a = 32'h2000_0040; axi.arready = 1'b1;
    step();
    c_strobe = 1'b0;
    step();
    chk("rr_rready_before", axi.rready, 1'b1);
    #2 clrn = 1'b0;
    #1;
    chk("rr_rready_async", axi.rready, 1'b0);
    chk("rr_arvalid_async", axi.arvalid, 1'b0);
    chk("rr_c_ready_async", c_ready, 1'b0);
    chk("rr_bus_err_async", bus_err, 1'b0);
    chk("rr_c_rdata_async", c_rdata, 32'h0);
    step();
    clrn = 1'b1;
    axi.arready = 1'b0;
    c_strobe = 1'b1; c_rw = 1'b0; c_a = 32'h3000_0004;
    step();
    chk("rr_fresh_arvalid", axi.arvalid, 1'b1);
    chk("rr_fresh_araddr", axi.araddr, 32'h3000_0004);
    c_strobe = 1'b0;
    step();
    chk("rr_wait_arvalid", axi.arvalid, 1'b1);
    axi.arready = 1'b1;
    step();
    chk("rr_wait_rready", axi.rready, 1'b1);
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D;
    step();
    chk("rr_wait_c_ready", c_ready, 1'b1);
    chk("rr_wait_c_rdata", c_rdata, 32'hCAFE_F00D);
    axi.rvalid = 1'b0;
    step();
    chk("rr_wait_c_ready_off", c_ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/d_axi_bridge.md
# d_axi_bridge

Single-outstanding bridge between the data cache's memory-side port and an AXI4 master interface. It converts each strobed word request (uncached read miss or write-through store) into one single-beat AXI read or write and returns a one-cycle `c_ready` pulse with read data. It sits directly downstream of the data cache and upstream of the SoC AXI interconnect.

## Interface

Parameters:

- `A_WIDTH`, 32, address width.
- `AXI_ID`, 4'd1, value driven on `arid`, `awid` and `wid`.

Ports:

- `clk` in 1: clock.
- `clrn` in 1: asynchronous, active-low reset.
- `c_a` in `A_WIDTH`: request address, word aligned. Connects to the cache's `m_a`.
- `c_wdata` in 32: write data. Connects to the cache's `m_din`.
- `c_rdata` out 32: read data. Connects to the cache's `m_dout`.
- `c_strobe` in 1: request valid.
- `c_rw` in 1: 0 = read, 1 = write.
- `c_ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: sticky; set on any non-OKAY `rresp`/`bresp`.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1.
- `wid` out 4, `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation

- Constant outputs:
  - `arlen` = `awlen` = 0
  - `arsize` = `awsize` = 3'b010
  - `arburst` = `awburst` = 2'b01
  - `wstrb` = 4'hF
  - `wlast` = 1
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE:
  - If `c_strobe`: latch `c_a` into `addr_q` and `c_wdata` into `wdata_q`.
  - `c_rw` = 0 → RADDR; `c_rw` = 1 → WREQ.
  - Otherwise stay in IDLE.
- RADDR: `arvalid` = 1, `araddr` = `addr_q`. On `arready` → RDATA.
- RDATA: `rready` = 1.
  - On `rvalid`: latch `rdata` into `c_rdata`; if `rresp` != 0, set `bus_err`; → DONE.
  - `rid` and `rlast` are ignored.
- WREQ: `awvalid` and `wvalid` are asserted together and handshake independently.
  - Flags `aw_done` and `w_done` record each accepted channel. Each valid drops the cycle after its own handshake.
  - When both are done (including same-cycle acceptance of both) → WRESP; clear both flags.
  - `awaddr` = `addr_q`, `wdata` = `wdata_q`.
- WRESP: `bready` = 1. On `bvalid`: if `bresp` != 0, set `bus_err`; → DONE.
- DONE: `c_ready` = 1 for exactly this cycle → IDLE. `c_strobe` is not sampled in DONE.
- Latched request: `c_a`, `c_wdata` and `c_rw` are sampled only in IDLE. Later changes have no effect on the current transaction.
- `c_strobe` dropping mid-transaction: the AXI transaction still completes and DONE still pulses `c_ready`. AXI transactions are never aborted.
- `c_rdata` holds its last read value until the next read completes. Writes do not modify it.
- `bus_err` clears only on reset.

## Timing

- Reset values (asynchronous on `clrn` low):
  - State = IDLE.
  - All valid/ready outputs = 0, `c_ready` = 0.
  - `c_rdata` = 0, `addr_q` = 0, `wdata_q` = 0, `bus_err` = 0, `aw_done` = `w_done` = 0.
  - Reset mid-transaction drops all AXI valids immediately. The interconnect is reset by the same `clrn`.
- All AXI and `c_*` outputs are driven from registers or directly from the state; there is no combinational input-to-output path.
- Minimum latency, with the slave ready immediately:
  - Strobe sampled at edge 0.
  - `arvalid`/`awvalid` high in cycle 1.
  - Data/response accepted in cycle 2.
  - `c_ready` high in cycle 3.
  - Each slave wait cycle adds exactly one cycle.
- Back-to-back requests: with `c_strobe` held high, a new request is sampled in the IDLE cycle following DONE. Throughput is at most one request per 4 cycles.
- Only one outstanding transaction at any time. At most one of {AR, R, AW/W, B} activity is in flight.
- AXI valids stay asserted and stable until their handshake, per AXI rules.

## Test plan

- Read, zero-wait slave: strobe, rw=0, `c_a`=0x1FC0_0010, `rdata`=0xDEAD_BEEF.
  - `arvalid` in cycle 1 with `araddr`=0x1FC0_0010 and `arid`=1.
  - `c_ready` pulse in cycle 3 with `c_rdata`=0xDEAD_BEEF.
- Write, `wready` 2 cycles after `awready`: `c_wdata`=0x1234_5678.
  - `awvalid` drops after its own handshake; `wvalid` holds until `wready`.
  - `wstrb`=0xF, `wlast`=1.
  - `bready` asserted only after both channels are done; `c_ready` one cycle after `bvalid`.
- Simultaneous `awready`/`wready` in cycle 1 → WRESP in cycle 2, `c_ready` in cycle 3.
- Back-to-back read then write with `c_strobe` held high:
  - Exactly one `c_ready` pulse per request.
  - The second `araddr`/`awaddr` matches the second request's address.
  - No duplicate AXI transaction.
- `bresp`=2'b10 on a write → `bus_err`=1 and stays 1 across subsequent OKAY reads; `c_ready` still pulses.
- `clrn` asserted while in RDATA with `rvalid` low:
  - All valids/readies go to 0 asynchronously, `c_ready`=0.
  - After release, the next strobe starts a fresh RADDR.
